// File: rtl/axi_pkg.sv
// Shared AXI encodings and FSM state constants for the SRAM-backed AXI4 slave.
package axi_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    localparam logic [0:0] R_IDLE  = 1'b0;
    localparam logic [0:0] R_BURST = 1'b1;

    localparam logic [1:0] W_IDLE  = 2'b00;
    localparam logic [1:0] W_DATA  = 2'b01;
    localparam logic [1:0] W_RESP  = 2'b10;

    // Only these lengths form a legal wrapping burst; anything else falls back to INCR.
    function automatic logic is_wrap_len(input logic [7:0] len);
        return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Combinational next-beat address for an AXI burst (FIXED / INCR / WRAP).
module axi_burst_addr
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [2:0]        i_size,
    input  logic [7:0]        i_len,
    input  logic [1:0]        i_burst,
    output logic [ADDR_W-1:0] o_next
);

    logic [ADDR_W-1:0] w_step;
    logic [ADDR_W-1:0] w_incr;
    logic [ADDR_W-1:0] w_mask;

    assign w_step = ADDR_W'(1) << i_size;
    assign w_incr = i_addr + w_step;
    // Window of (LEN+1) beats; the incremented address keeps only its in-window bits.
    assign w_mask = ((ADDR_W'(i_len) + ADDR_W'(1)) << i_size) - ADDR_W'(1);

    always_comb begin
        o_next = w_incr;
        case (i_burst)
            BURST_FIXED: o_next = i_addr;
            BURST_WRAP: begin
                if (is_wrap_len(i_len)) begin
                    o_next = (i_addr & ~w_mask) | (w_incr & w_mask);
                end
            end
            default: o_next = w_incr;
        endcase
    end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave backed by an on-chip word array; independent read and write bursts.
// Optional AXI_SLAVE_DECERR_EN: out-of-window beats answer DECERR and writes are dropped.
module axi_sram_slave
    import axi_pkg::*;
#(
    parameter int                ADDR_W = 32,
    parameter int                DATA_W = 64,
    parameter int                ID_W   = 4,
    parameter int                DEPTH  = 4096,
    parameter logic [ADDR_W-1:0] BASE   = ADDR_W'(32'h8000_0000)
) (
    input  logic                  io_basic_ACLK,
    input  logic                  io_basic_ARESETn,
    input  logic [ID_W-1:0]       io_axiRa_ARID,
    input  logic [ADDR_W-1:0]     io_axiRa_ARADDR,
    input  logic [7:0]            io_axiRa_ARLEN,
    input  logic [2:0]            io_axiRa_ARSIZE,
    input  logic [1:0]            io_axiRa_ARBURST,
    input  logic                  io_axiRa_ARVALID,
    output logic                  io_axiRa_ARREADY,
    output logic [ID_W-1:0]       io_axiRd_RID,
    output logic [DATA_W-1:0]     io_axiRd_RDATA,
    output logic [1:0]            io_axiRd_RRESP,
    output logic                  io_axiRd_RLAST,
    output logic                  io_axiRd_RVALID,
    input  logic                  io_axiRd_RREADY,
    input  logic [ID_W-1:0]       io_axiWa_AWID,
    input  logic [ADDR_W-1:0]     io_axiWa_AWADDR,
    input  logic [7:0]            io_axiWa_AWLEN,
    input  logic [2:0]            io_axiWa_AWSIZE,
    input  logic [1:0]            io_axiWa_AWBURST,
    input  logic                  io_axiWa_AWVALID,
    output logic                  io_axiWa_AWREADY,
    input  logic [DATA_W-1:0]     io_axiWd_WDATA,
    input  logic [DATA_W/8-1:0]   io_axiWd_WSTRB,
    input  logic                  io_axiWd_WLAST,
    input  logic                  io_axiWd_WVALID,
    output logic                  io_axiWd_WREADY,
    output logic [ID_W-1:0]       io_axiWr_BID,
    output logic [1:0]            io_axiWr_BRESP,
    output logic                  io_axiWr_BVALID,
    input  logic                  io_axiWr_BREADY
);

    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];

    function automatic logic [IDX_W-1:0] f_idx(input logic [ADDR_W-1:0] a);
        return IDX_W'((a - BASE) >> OFF_W);
    endfunction

    logic [0:0]        r_rstate;
    logic [ADDR_W-1:0] r_raddr;
    logic [7:0]        r_rlen, r_rcnt;
    logic [2:0]        r_rsize;
    logic [1:0]        r_rburst, r_rresp;
    logic [ID_W-1:0]   r_rid;
    logic [DATA_W-1:0] r_rdata;
    logic              r_rvalid, r_rlast;

    logic [1:0]        r_wstate;
    logic [ADDR_W-1:0] r_waddr;
    logic [7:0]        r_wlen, r_wcnt;
    logic [2:0]        r_wsize;
    logic [1:0]        r_wburst, r_bresp;
    logic [ID_W-1:0]   r_bid;
    logic              r_bvalid, r_werr;

    logic [ADDR_W-1:0] w_rnext, w_wnext, w_rd_addr;
    logic [DATA_W-1:0] w_rd_word;
    logic              w_ar_hs, w_r_hs, w_rd_load, w_w_hs, w_wr_en, w_rd_err, w_wr_err;
    logic              w_unused_wlast;

    // Write bursts end on the beat count, so WLAST carries no information here.
    assign w_unused_wlast = io_axiWd_WLAST;

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_rd_addr (
        .i_addr (r_raddr),
        .i_size (r_rsize),
        .i_len  (r_rlen),
        .i_burst(r_rburst),
        .o_next (w_rnext)
    );

    axi_burst_addr #(.ADDR_W(ADDR_W)) u_wr_addr (
        .i_addr (r_waddr),
        .i_size (r_wsize),
        .i_len  (r_wlen),
        .i_burst(r_wburst),
        .o_next (w_wnext)
    );

    assign w_ar_hs   = io_axiRa_ARVALID && (r_rstate == R_IDLE);
    assign w_r_hs    = r_rvalid && io_axiRd_RREADY;
    assign w_w_hs    = io_axiWd_WVALID && (r_wstate == W_DATA);
    // The next beat is fetched the cycle the current one is accepted, keeping RVALID continuous.
    assign w_rd_load = w_ar_hs || (w_r_hs && !r_rlast);
    assign w_rd_addr = w_ar_hs ? io_axiRa_ARADDR : w_rnext;
    assign w_rd_word = r_mem[f_idx(w_rd_addr)];
    assign w_wr_en   = w_w_hs && !w_wr_err;

`ifdef AXI_SLAVE_DECERR_EN
    function automatic logic f_in_range(input logic [ADDR_W-1:0] a);
        return (a - BASE) < ADDR_W'(DEPTH * STRB_W);
    endfunction
    assign w_rd_err = !f_in_range(w_rd_addr);
    assign w_wr_err = !f_in_range(r_waddr);
`else
    assign w_rd_err = 1'b0;
    assign w_wr_err = 1'b0;
`endif

    always_ff @(posedge io_basic_ACLK or negedge io_basic_ARESETn) begin
        if (!io_basic_ARESETn) begin
            r_rstate <= R_IDLE;
            r_raddr  <= '0;
            r_rlen   <= '0;
            r_rcnt   <= '0;
            r_rsize  <= '0;
            r_rburst <= '0;
            r_rid    <= '0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_rvalid <= 1'b0;
            r_rlast  <= 1'b0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (io_axiRa_ARVALID) begin
                        r_rid    <= io_axiRa_ARID;
                        r_raddr  <= io_axiRa_ARADDR;
                        r_rlen   <= io_axiRa_ARLEN;
                        r_rsize  <= io_axiRa_ARSIZE;
                        r_rburst <= io_axiRa_ARBURST;
                        r_rcnt   <= '0;
                        r_rvalid <= 1'b1;
                        r_rlast  <= (io_axiRa_ARLEN == 8'd0);
                        r_rstate <= R_BURST;
                    end
                end
                default: begin
                    if (w_r_hs) begin
                        if (r_rlast) begin
                            r_rvalid <= 1'b0;
                            r_rlast  <= 1'b0;
                            r_rstate <= R_IDLE;
                        end else begin
                            r_raddr <= w_rnext;
                            r_rcnt  <= r_rcnt + 8'd1;
                            r_rlast <= ((r_rcnt + 8'd1) == r_rlen);
                        end
                    end
                end
            endcase
            if (w_rd_load) begin
                r_rdata <= w_rd_err ? '0 : w_rd_word;
                r_rresp <= w_rd_err ? RESP_DECERR : RESP_OKAY;
            end
        end
    end

    always_ff @(posedge io_basic_ACLK or negedge io_basic_ARESETn) begin
        if (!io_basic_ARESETn) begin
            r_wstate <= W_IDLE;
            r_waddr  <= '0;
            r_wlen   <= '0;
            r_wcnt   <= '0;
            r_wsize  <= '0;
            r_wburst <= '0;
            r_bid    <= '0;
            r_bresp  <= RESP_OKAY;
            r_bvalid <= 1'b0;
            r_werr   <= 1'b0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (io_axiWa_AWVALID) begin
                        r_bid    <= io_axiWa_AWID;
                        r_waddr  <= io_axiWa_AWADDR;
                        r_wlen   <= io_axiWa_AWLEN;
                        r_wsize  <= io_axiWa_AWSIZE;
                        r_wburst <= io_axiWa_AWBURST;
                        r_wcnt   <= '0;
                        r_werr   <= 1'b0;
                        r_wstate <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_w_hs) begin
                        r_waddr <= w_wnext;
                        r_wcnt  <= r_wcnt + 8'd1;
                        r_werr  <= r_werr | w_wr_err;
                        if (r_wcnt == r_wlen) begin
                            r_bvalid <= 1'b1;
                            r_bresp  <= (r_werr | w_wr_err) ? RESP_DECERR : RESP_OKAY;
                            r_wstate <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (io_axiWr_BREADY) begin
                        r_bvalid <= 1'b0;
                        r_wstate <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Array contents survive reset; only the strobed byte lanes are written.
    always_ff @(posedge io_basic_ACLK) begin
        if (w_wr_en) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (io_axiWd_WSTRB[b]) begin
                    r_mem[f_idx(r_waddr)][8*b +: 8] <= io_axiWd_WDATA[8*b +: 8];
                end
            end
        end
    end

    assign io_axiRa_ARREADY = (r_rstate == R_IDLE);
    assign io_axiWa_AWREADY = (r_wstate == W_IDLE);
    assign io_axiWd_WREADY  = (r_wstate == W_DATA);
    assign io_axiRd_RID     = r_rid;
    assign io_axiRd_RDATA   = r_rdata;
    assign io_axiRd_RRESP   = r_rresp;
    assign io_axiRd_RLAST   = r_rlast;
    assign io_axiRd_RVALID  = r_rvalid;
    assign io_axiWr_BID     = r_bid;
    assign io_axiWr_BRESP   = r_bresp;
    assign io_axiWr_BVALID  = r_bvalid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Scoreboard bench for axi_sram_slave: reference word-array model, randomized bursts, reset abort.
module tb_axi_sram_slave;

    localparam int          DEPTH = 4096;
    localparam logic [31:0] BASE  = 32'h8000_0000;

    logic        clk, rst_n;
    logic [3:0]  arid, awid, rid, bid;
    logic [31:0] araddr, awaddr;
    logic [7:0]  arlen, awlen, wstrb;
    logic [2:0]  arsize, awsize;
    logic [1:0]  arburst, awburst, rresp, bresp;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic [63:0] rdata, wdata;

    axi_sram_slave #(.DEPTH(DEPTH)) dut (
        .io_basic_ACLK(clk),        .io_basic_ARESETn(rst_n),
        .io_axiRa_ARID(arid),       .io_axiRa_ARADDR(araddr),   .io_axiRa_ARLEN(arlen),
        .io_axiRa_ARSIZE(arsize),   .io_axiRa_ARBURST(arburst), .io_axiRa_ARVALID(arvalid),
        .io_axiRa_ARREADY(arready),
        .io_axiRd_RID(rid),         .io_axiRd_RDATA(rdata),     .io_axiRd_RRESP(rresp),
        .io_axiRd_RLAST(rlast),     .io_axiRd_RVALID(rvalid),   .io_axiRd_RREADY(rready),
        .io_axiWa_AWID(awid),       .io_axiWa_AWADDR(awaddr),   .io_axiWa_AWLEN(awlen),
        .io_axiWa_AWSIZE(awsize),   .io_axiWa_AWBURST(awburst), .io_axiWa_AWVALID(awvalid),
        .io_axiWa_AWREADY(awready),
        .io_axiWd_WDATA(wdata),     .io_axiWd_WSTRB(wstrb),     .io_axiWd_WLAST(wlast),
        .io_axiWd_WVALID(wvalid),   .io_axiWd_WREADY(wready),
        .io_axiWr_BID(bid),         .io_axiWr_BRESP(bresp),     .io_axiWr_BVALID(bvalid),
        .io_axiWr_BREADY(bready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {logic [3:0] id; logic [63:0] data; logic [1:0] resp; logic last;} rexp_t;
    typedef struct packed {logic [3:0] id; logic [1:0] resp;} bexp_t;

    rexp_t       rq[$];
    bexp_t       bq[$];
    logic [63:0] mdl [DEPTH];
    int          checks = 0;
    int          errors = 0;
    int          rmode  = 2;   // 0 random, 1 toggle, 2 always ready, 3 never ready

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Address of beat i computed directly from the start address (no iteration).
    function automatic logic [31:0] beat_addr(input logic [31:0] start, input int size,
                                              input int len, input int burst, input int i);
        int unsigned step, total;
        logic [31:0] wbase;
        step = 1 << size;
        if (burst == 0) return start;
        if (burst == 2 && (len == 1 || len == 3 || len == 7 || len == 15)) begin
            total = (len + 1) * step;
            wbase = start - (start % total);
            return wbase + (((start - wbase) + i * step) % total);
        end
        return start + i * step;
    endfunction

    function automatic int widx(input logic [31:0] a);
        return int'(((a - BASE) >> 3) % DEPTH);
    endfunction

    function automatic bit in_range(input logic [31:0] a);
`ifdef AXI_SLAVE_DECERR_EN
        return (a - BASE) < DEPTH * 8;
`else
        return (a == a);
`endif
    endfunction

    function automatic logic rdy(input int ch);
        case (ch)
            0: return arready;
            1: return awready;
            default: return wready;
        endcase
    endfunction

    task automatic wait_hs(input int ch, input string name);
        int n = 0;
        @(negedge clk);
        while (!rdy(ch) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!rdy(ch)) begin
            checks++;
            errors++;
            $display("FAIL %s handshake timeout actual=0 required=1", name);
        end
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while ((rq.size() != 0 || bq.size() != 0) && n < 3000) begin
            @(posedge clk);
            n++;
        end
        if (n >= 3000) begin
            checks++;
            errors++;
            $display("FAIL %s drain timeout actual rq=%0d bq=%0d required 0", name, rq.size(), bq.size());
            rq.delete();
            bq.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rd_burst(input logic [3:0] id, input logic [31:0] a, input int len,
                            input int size, input int burst);
        for (int i = 0; i <= len; i++) begin
            logic [31:0] ba;
            ba = beat_addr(a, size, len, burst, i);
            rq.push_back('{id, in_range(ba) ? mdl[widx(ba)] : 64'd0,
                           in_range(ba) ? 2'b00 : 2'b11, (i == len)});
        end
        arid = id; araddr = a; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
        arvalid = 1'b1;
        wait_hs(0, "ar");
        @(posedge clk);
        #1 arvalid = 1'b0;
        wait_drain("read");
    endtask

    task automatic wr_burst(input logic [3:0] id, input logic [31:0] a, input int len,
                            input int size, input int burst, input logic [63:0] d0,
                            input logic [7:0] s0, input bit rnd);
        logic [63:0] dq[$];
        logic [7:0]  sq[$];
        bit          err = 0;
        for (int i = 0; i <= len; i++) begin
            logic [31:0] ba;
            logic [63:0] d;
            logic [7:0]  s;
            d = rnd ? {$urandom, $urandom} : d0 * 64'(i + 1);
            s = rnd ? 8'($urandom) : s0;
            dq.push_back(d);
            sq.push_back(s);
            ba = beat_addr(a, size, len, burst, i);
            if (!in_range(ba)) err = 1;
            else for (int b = 0; b < 8; b++) if (s[b]) mdl[widx(ba)][8*b +: 8] = d[8*b +: 8];
        end
        bq.push_back('{id, err ? 2'b11 : 2'b00});
        awid = id; awaddr = a; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
        awvalid = 1'b1;
        wait_hs(1, "aw");
        @(posedge clk);
        #1 awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (rnd && ($urandom % 4 == 0)) begin
                @(posedge clk);
                #1;
            end
            wdata = dq[i]; wstrb = sq[i]; wlast = (i == len); wvalid = 1'b1;
            wait_hs(2, "w");
            @(posedge clk);
            #1 wvalid = 1'b0;
        end
        wait_drain("write");
    endtask

    initial begin
        rready = 1'b1;
        bready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: rready = 1'($urandom);
                1: rready = ~rready;
                2: rready = 1'b1;
                default: rready = 1'b0;
            endcase
            bready = ($urandom % 4) != 0;
        end
    end

    // Monitor: pops an expectation for every accepted beat / response.
    bit          stall = 0;
    logic [63:0] st_data;
    logic [6:0]  st_ctl;
    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 0;
        end else begin
            if (bvalid && bready) begin
                if (bq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL b_unexpected actual bid=%0d required none", bid);
                end else begin
                    bexp_t e;
                    e = bq.pop_front();
                    chk("bid", 64'(bid), 64'(e.id));
                    chk("bresp", 64'(bresp), 64'(e.resp));
                end
            end
            if (stall) begin
                chk("r_valid_held", 64'(rvalid), 64'd1);
                chk("r_stable_data", rdata, st_data);
                chk("r_stable_ctl", 64'({rid, rresp, rlast}), 64'(st_ctl));
            end
            stall = 0;
            if (rvalid && rready) begin
                if (rq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL r_unexpected actual data=%h required none", rdata);
                end else begin
                    rexp_t e;
                    e = rq.pop_front();
                    chk("rid", 64'(rid), 64'(e.id));
                    chk("rdata", rdata, e.data);
                    chk("rresp", 64'(rresp), 64'(e.resp));
                    chk("rlast", 64'(rlast), 64'(e.last));
                end
            end else if (rvalid) begin
                stall   = 1;
                st_data = rdata;
                st_ctl  = {rid, rresp, rlast};
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] oldw, neww;
        rst_n = 1'b0;
        arvalid = 0; awvalid = 0; wvalid = 0; wlast = 0;
        arid = 0; araddr = 0; arlen = 0; arsize = 0; arburst = 0;
        awid = 0; awaddr = 0; awlen = 0; awsize = 0; awburst = 0; wdata = 0; wstrb = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 64'(arready), 64'd1);
        chk("rst_awready", 64'(awready), 64'd1);
        chk("rst_wready", 64'(wready), 64'd0);
        chk("rst_valids", 64'({rvalid, bvalid, rlast}), 64'd0);
        chk("rst_ids_resp", 64'({rid, bid, rresp, bresp}), 64'd0);
        chk("rst_rdata", rdata, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Directed: INCR write, stalled read-back, WRAP read.
        wr_burst(4'd3, BASE, 3, 3, 1, {8{8'h11}}, 8'hFF, 0);
        rmode = 1;
        rd_burst(4'd5, BASE, 3, 3, 1);
        rmode = 2;
        rd_burst(4'd6, BASE + 32'h10, 3, 3, 2);

        // Fill words 0..63 so later random reads only see written data.
        for (int k = 0; k < 4; k++) wr_burst(4'(k), BASE + 32'(k * 128), 15, 3, 1, 0, 8'hFF, 1);

        // Partial strobe over a zeroed word.
        wr_burst(4'd1, BASE + 32'h100, 0, 3, 1, 64'd0, 8'hFF, 0);
        wr_burst(4'd2, BASE + 32'h100, 0, 3, 1, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
        rd_burst(4'd4, BASE + 32'h100, 0, 3, 1);

        // Read and write handshake on the same word in the same cycle.
        oldw = mdl[40];
        neww = {$urandom, $urandom};
        rq.push_back('{4'd7, oldw, 2'b00, 1'b1});
        mdl[40] = neww;
        bq.push_back('{4'd6, 2'b00});
        awid = 4'd6; awaddr = BASE + 32'd320; awlen = 0; awsize = 3; awburst = 1; awvalid = 1;
        wait_hs(1, "conc_aw");
        @(posedge clk);
        #1 awvalid = 0;
        arid = 4'd7; araddr = BASE + 32'd320; arlen = 0; arsize = 3; arburst = 1; arvalid = 1;
        wdata = neww; wstrb = 8'hFF; wlast = 1; wvalid = 1;
        @(negedge clk);
        chk("conc_arready", 64'(arready), 64'd1);
        chk("conc_wready", 64'(wready), 64'd1);
        @(posedge clk);
        #1 arvalid = 0; wvalid = 0;
        wait_drain("concurrent");
        rd_burst(4'd8, BASE + 32'd320, 0, 3, 1);

        // Randomized write/read pairs inside the filled region.
        rmode = 0;
        for (int t = 0; t < 30; t++) begin
            for (int dir = 0; dir < 2; dir++) begin
                int sz, bu, ln, wd;
                logic [31:0] a;
                sz = int'($urandom % 4);
                bu = int'($urandom % 3);
                ln = (bu == 2) ? ((2 << ($urandom % 4)) - 1) : int'($urandom % 16);
                wd = int'($urandom % 48);
                a  = BASE + 32'(wd * 8) + (32'($urandom % 8) & ~32'((1 << sz) - 1));
                if (dir == 0) wr_burst(4'($urandom), a, ln, sz, bu, 0, 0, 1);
                else          rd_burst(4'($urandom), a, ln, sz, bu);
            end
        end

        // Reset in the middle of a stalled read burst.
        rmode = 3;
        @(posedge clk);
        #1;
        arid = 4'd9; araddr = BASE; arlen = 7; arsize = 3; arburst = 1; arvalid = 1;
        wait_hs(0, "rst_ar");
        @(posedge clk);
        #1 arvalid = 0;
        @(posedge clk);
        #1;
        chk("pre_rst_rvalid", 64'(rvalid), 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_async_rvalid", 64'(rvalid), 64'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_rvalid", 64'(rvalid), 64'd0);
        chk("rst_edge_arready", 64'(arready), 64'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_arready", 64'(arready), 64'd1);
        chk("post_rst_rvalid", 64'({rvalid, rlast}), 64'd0);
        rmode = 2;
        rd_burst(4'd10, BASE, 7, 3, 1);

`ifdef AXI_SLAVE_DECERR_EN
        rd_burst(4'd2, 32'h1000_0000, 0, 3, 1);
        wr_burst(4'd3, BASE + 32'(DEPTH * 8 - 8), 1, 3, 1, 64'h5, 8'hFF, 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
